uart_rx_fifo: RTL and testbench

//  Receive-side byte buffer between the uart receiver and the command interpreter.
//  - Accepts each received byte with a one-cycle acknowledge pulse.
//  - Waits a hold-off period so the uart can drop its ready flag.
//  - Stores bytes in a first-word-fall-through FIFO; the consumer pops them with a take strobe.
//  - Reports fill level and a sticky overflow flag.

---
 rtl/uart_rx_fifo_if.sv | 28 ++
 rtl/uart_rx_fifo.sv | 108 ++++++++++
 tb/tb_uart_rx_fifo.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_if.sv
// Bundles the uart receive handshake and the consumer-side FIFO signals.
// No latency of its own; it only groups wires.
// Backpressure: the uart is always drained, and the consumer pops with dout_take.
interface uart_rx_fifo_if #(
    parameter int DEPTH_LOG2 = 3
);
    logic [7:0]          rxd_data;
    logic                rxd_ready;
    logic                rxd_read;
    logic [7:0]          dout;
    logic                dout_valid;
    logic                dout_take;
    logic [DEPTH_LOG2:0] count;
    logic                overflow;
    logic                overflow_clr;

    // Environment side: the uart plus the command interpreter.
    modport master (
        output rxd_data, rxd_ready, dout_take, overflow_clr,
        input  rxd_read, dout, dout_valid, count, overflow
    );

    // Buffer side.
    modport slave (
        input  rxd_data, rxd_ready, dout_take, overflow_clr,
        output rxd_read, dout, dout_valid, count, overflow
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Captures uart bytes into a first-word-fall-through FIFO and acknowledges each one with a single-cycle pulse.
// Latency: a byte captured in cycle N appears on dout in cycle N+1, and rxd_read pulses in cycle N+1.
// Backpressure: none toward the uart. A byte that arrives while the FIFO is full is dropped and sets a sticky overflow flag.
module uart_rx_fifo #(
    parameter int DEPTH_LOG2 = 3,
    parameter int HOLDOFF    = 8
) (
    input  logic           clk,
    input  logic           rst,
    uart_rx_fifo_if.slave  bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int HW    = $clog2(HOLDOFF + 1);
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t                  state, state_nxt;
    logic [HW-1:0]           holdcnt, holdcnt_nxt;
    logic                    capture;

    logic [7:0]              mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   wptr, rptr;
    logic [DEPTH_LOG2:0]     cnt;
    logic                    empty, full, pop, push, drop;
    logic                    rd_pulse, ovf;

    assign empty = (cnt == '0);
    assign full  = (cnt == FULL_CNT);
    // A pop at the same edge frees a slot, so a capture into a full FIFO still fits.
    assign pop   = bus.dout_take && !empty;
    assign push  = capture && (!full || pop);
    assign drop  = capture && full && !pop;

    // Capture state and hold-off counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            holdcnt <= '0;
        end else begin
            state   <= state_nxt;
            holdcnt <= holdcnt_nxt;
        end
    end

    // Next-state logic: sample rxd_ready only in IDLE, then ignore it for HOLDOFF cycles.
    always_comb begin
        state_nxt   = state;
        holdcnt_nxt = holdcnt;
        capture     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.rxd_ready) begin
                    capture     = 1'b1;
                    state_nxt   = HOLD;
                    holdcnt_nxt = HW'(HOLDOFF);
                end
            end
            HOLD: begin
                if (holdcnt <= HW'(1)) begin
                    state_nxt   = IDLE;
                    holdcnt_nxt = '0;
                end else begin
                    holdcnt_nxt = holdcnt - HW'(1);
                end
            end
            default: begin
                state_nxt   = IDLE;
                holdcnt_nxt = '0;
            end
        endcase
    end

    // Pointers, fill level, acknowledge pulse and sticky overflow. A drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            cnt      <= '0;
            rd_pulse <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            if (push) wptr <= wptr + DEPTH_LOG2'(1);
            if (pop)  rptr <= rptr + DEPTH_LOG2'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + (DEPTH_LOG2 + 1)'(1);
                2'b01:   cnt <= cnt - (DEPTH_LOG2 + 1)'(1);
                default: cnt <= cnt;
            endcase
            rd_pulse <= capture;
            if (drop)
                ovf <= 1'b1;
            else if (bus.overflow_clr)
                ovf <= 1'b0;
        end
    end

    // Storage array. It is left unreset because only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= bus.rxd_data;
    end

    assign bus.rxd_read   = rd_pulse;
    assign bus.dout_valid = !empty;
    assign bus.dout       = empty ? 8'd0 : mem[rptr];
    assign bus.count      = cnt;
    assign bus.overflow   = ovf;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboarded bench for uart_rx_fifo. Stimulus pushes the bytes it expects to see, and a negedge monitor checks every pop.
// Latency checks are made one time step after the active edge.
// Backpressure is exercised through full-FIFO drops, a take that coincides with a write while full, and takes while empty.
module tb_uart_rx_fifo;
    localparam int DL = 3;
    localparam int HOLDOFF = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] exp_q [$];
    logic [7:0] mon_exp;

    uart_rx_fifo_if #(.DEPTH_LOG2(DL)) bus();

    uart_rx_fifo #(.DEPTH_LOG2(DL), .HOLDOFF(HOLDOFF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: any pop the DUT performs must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && bus.dout_valid && bus.dout_take) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pop: got %0h expected none", bus.dout);
            end else begin
                mon_exp = exp_q.pop_front();
                if (bus.dout !== mon_exp) begin
                    errors++;
                    $display("FAIL pop_data: got %0h expected %0h at %0t", bus.dout, mon_exp, $time);
                end
            end
        end
    end

    // Present one byte, check the acknowledge pulse, then wait until the FSM is back in IDLE.
    task automatic send(input logic [7:0] b, input bit store);
        if (store) exp_q.push_back(b);
        bus.rxd_data  = b;
        bus.rxd_ready = 1'b1;
        tick();
        bus.rxd_ready = 1'b0;
        check("rxd_read_pulse", bus.rxd_read, 1);
        tick();
        check("rxd_read_low", bus.rxd_read, 0);
        repeat (HOLDOFF - 1) tick();
    endtask

    task automatic take();
        bus.dout_take = 1'b1;
        tick();
        bus.dout_take = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 16 && bus.dout_valid; k++) take();
        check("drained_valid", bus.dout_valid, 0);
        check("drained_count", bus.count, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int last;
        int pulses;
        logic [7:0] d;
        bus.rxd_data = 8'h00;
        bus.rxd_ready = 1'b0;
        bus.dout_take = 1'b0;
        bus.overflow_clr = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_rxd_read", bus.rxd_read, 0);
        check("rst_valid", bus.dout_valid, 0);
        check("rst_dout", bus.dout, 0);
        check("rst_count", bus.count, 0);
        check("rst_overflow", bus.overflow, 0);

        // 1: single byte latency and pop.
        exp_q.push_back(8'h06);
        bus.rxd_data = 8'h06;
        bus.rxd_ready = 1'b1;
        tick();
        bus.rxd_ready = 1'b0;
        check("t1_read", bus.rxd_read, 1);
        check("t1_valid", bus.dout_valid, 1);
        check("t1_dout", bus.dout, 8'h06);
        check("t1_count", bus.count, 1);
        tick();
        check("t1_read_once", bus.rxd_read, 0);
        repeat (HOLDOFF - 1) tick();
        take();
        check("t1_valid_after", bus.dout_valid, 0);
        check("t1_count_after", bus.count, 0);

        // 2: fill, overflow, clear versus drop priority, then drain in order.
        for (int i = 0; i < 8; i++) send(8'(i), 1'b1);
        check("t2_full_count", bus.count, 8);
        check("t2_no_ovf", bus.overflow, 0);
        send(8'hAA, 1'b0);
        check("t2_ovf", bus.overflow, 1);
        check("t2_count_kept", bus.count, 8);
        bus.overflow_clr = 1'b1;
        tick();
        bus.overflow_clr = 1'b0;
        check("t2_ovf_clr", bus.overflow, 0);
        bus.rxd_data = 8'hBB;
        bus.rxd_ready = 1'b1;
        bus.overflow_clr = 1'b1;
        tick();
        bus.rxd_ready = 1'b0;
        bus.overflow_clr = 1'b0;
        check("t2_set_wins", bus.overflow, 1);
        check("t2_read_drop", bus.rxd_read, 1);
        check("t2_count_drop", bus.count, 8);
        repeat (HOLDOFF) tick();
        drain();
        bus.overflow_clr = 1'b1;
        tick();
        bus.overflow_clr = 1'b0;
        check("t2_ovf_clr2", bus.overflow, 0);

        // 3: interleaved traffic across pointer wrap.
        for (int i = 0; i < 20; i++) begin
            send(8'h10 + 8'(i), 1'b1);
            if (i >= 3) take();
        end
        check("t3_count", bus.count, 3);
        drain();
        check("t3_no_ovf", bus.overflow, 0);

        // 4: write and pop in the same cycle while full.
        for (int i = 0; i < 8; i++) send(8'h30 + 8'(i), 1'b1);
        exp_q.push_back(8'h55);
        bus.rxd_data = 8'h55;
        bus.rxd_ready = 1'b1;
        bus.dout_take = 1'b1;
        tick();
        bus.rxd_ready = 1'b0;
        bus.dout_take = 1'b0;
        check("t4_count", bus.count, 8);
        check("t4_no_ovf", bus.overflow, 0);
        check("t4_read", bus.rxd_read, 1);
        repeat (HOLDOFF) tick();
        drain();

        // 5: rxd_ready held for 40 cycles. Captures happen at cycles 0, 9, 18, 27 and 36.
        exp_q.push_back(8'h60);
        exp_q.push_back(8'h69);
        exp_q.push_back(8'h72);
        exp_q.push_back(8'h7B);
        exp_q.push_back(8'h84);
        last = -1;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            d = 8'h60 + 8'(k);
            bus.rxd_data = d;
            bus.rxd_ready = 1'b1;
            tick();
            if (bus.rxd_read) begin
                pulses++;
                if (last >= 0) check("t5_gap", k - last, 9);
                last = k;
            end
        end
        bus.rxd_ready = 1'b0;
        check("t5_pulses", pulses, 5);
        check("t5_count", bus.count, 5);
        repeat (HOLDOFF) tick();
        drain();
        take();
        check("t5_empty_take_count", bus.count, 0);
        check("t5_empty_take_valid", bus.dout_valid, 0);
        check("t5_empty_take_dout", bus.dout, 0);

        // 6: reset while in HOLD with data stored, then reset coinciding with a capture.
        send(8'h90, 1'b0);
        send(8'h91, 1'b0);
        bus.rxd_data = 8'h92;
        bus.rxd_ready = 1'b1;
        tick();
        bus.rxd_ready = 1'b0;
        check("t6_count3", bus.count, 3);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_count", bus.count, 0);
        check("t6_valid", bus.dout_valid, 0);
        check("t6_read", bus.rxd_read, 0);
        check("t6_ovf", bus.overflow, 0);
        check("t6_dout", bus.dout, 0);
        bus.rxd_data = 8'h77;
        bus.rxd_ready = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.rxd_ready = 1'b0;
        check("t6_read_suppressed", bus.rxd_read, 0);
        check("t6_count_rst", bus.count, 0);
        exp_q.push_back(8'hA5);
        bus.rxd_data = 8'hA5;
        bus.rxd_ready = 1'b1;
        tick();
        bus.rxd_ready = 1'b0;
        check("t6_new_read", bus.rxd_read, 1);
        check("t6_new_dout", bus.dout, 8'hA5);
        check("t6_new_count", bus.count, 1);
        repeat (HOLDOFF) tick();
        take();
        check("t6_final_count", bus.count, 0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
